// File: rtl/pa_isa_pkg.sv
// Shared ISA definitions for the decode-front parser.
//   OP_W / REG_W / IMM_W : default field widths of an instruction word
//   FMT_SHORT / FMT_LONG : values of the format select
//   OPCODE_NOP           : opcode that is filtered out of the stream
//   decoded_t            : decoded instruction record at the default widths
package pa_isa_pkg;

  localparam int OP_W  = 7;
  localparam int REG_W = 5;
  localparam int IMM_W = 16;

  localparam logic FMT_SHORT = 1'b0;
  localparam logic FMT_LONG  = 1'b1;

  localparam logic [OP_W-1:0] OPCODE_NOP = '0;

  typedef struct packed {
    logic              format;
    logic              branch;
    logic [OP_W-1:0]   opcode;
    logic [REG_W-1:0]  prim;
    logic [IMM_W-1:0]  sec;
  } decoded_t;

endpackage

// File: rtl/parser_skid_buffer.sv
// Two-entry valid/ready register slice with flush.
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   flush                 : drop both entries at the next edge
//   in_valid/in_ready/in_data    : upstream handshake, in_ready registered
//   out_valid/out_ready/out_data : downstream handshake from the output register
module parser_skid_buffer #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         out_free;

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  // Output register may be loaded when empty or draining this cycle.
  assign out_free = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        // in_ready is low while the skid is full, so no input can arrive here.
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/parser_stream.sv
// Decode-front parser stage with valid/ready on both sides.
// Splits each instruction word into format, branch, opcode, primary register
// and secondary operand, drops NOP words (counting them) and buffers up to two
// decoded instructions.
//   clock_i, reset_i        : rising-edge clock, synchronous active-high reset
//   flush_i                 : discard everything buffered and this cycle's input
//   in_valid_i / in_ready_o : upstream handshake (in_ready_o registered)
//   instruction_i, format_i : raw word and its format (0 short, 1 long)
//   out_valid_o / out_ready_i : downstream handshake
//   format_o .. sec_operand_o : decoded fields, stable while out_valid_o waits
//   nop_count_o             : saturating count of NOPs dropped since reset
module parser_stream #(
  parameter  int OP_W    = pa_isa_pkg::OP_W,
  parameter  int REG_W   = pa_isa_pkg::REG_W,
  parameter  int IMM_W   = pa_isa_pkg::IMM_W,
  parameter  int CNT_W   = 16,
  localparam int INSTR_W = IMM_W + REG_W + OP_W + 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] instruction_i,
  input  logic               format_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               format_o,
  output logic               is_branch_o,
  output logic [OP_W-1:0]    opcode_o,
  output logic [REG_W-1:0]   prim_operand_o,
  output logic [IMM_W-1:0]   sec_operand_o,
  output logic [CNT_W-1:0]   nop_count_o
);

  import pa_isa_pkg::*;

  localparam int DEC_W = 2 + OP_W + REG_W + IMM_W;

  logic               branch;
  logic [OP_W-1:0]    opcode;
  logic [REG_W-1:0]   prim;
  logic [IMM_W-1:0]   sec;
  logic               is_nop;
  logic               accept;
  logic               unused_reserved;
  logic [DEC_W-1:0]   dec_data;
  logic [DEC_W-1:0]   out_data;

  assign unused_reserved = instruction_i[INSTR_W-1];
  assign branch = instruction_i[INSTR_W-2];
  assign opcode = instruction_i[INSTR_W-3 -: OP_W];
  assign prim   = instruction_i[IMM_W+REG_W-1 -: REG_W];

  // Short format carries a register in the top of the immediate field; the
  // bits below it are don't-care.
  assign sec = (format_i == FMT_LONG) ? instruction_i[IMM_W-1:0]
             : {{(IMM_W-REG_W){1'b0}}, instruction_i[IMM_W-1 -: REG_W]};

  assign is_nop   = (opcode == OP_W'(OPCODE_NOP));
  assign accept   = in_valid_i & in_ready_o;
  assign dec_data = {format_i, branch, opcode, prim, sec};

  // NOPs are handshaken normally but never enter the buffer.
  parser_skid_buffer #(.W(DEC_W)) u_skid (
    .clk       (clock_i),
    .rst       (reset_i),
    .flush     (flush_i),
    .in_valid  (in_valid_i & ~is_nop),
    .in_ready  (in_ready_o),
    .in_data   (dec_data),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (out_data)
  );

  assign {format_o, is_branch_o, opcode_o, prim_operand_o, sec_operand_o} = out_data;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      nop_count_o <= '0;
    end else if (accept && is_nop && !flush_i && (nop_count_o != '1)) begin
      nop_count_o <= nop_count_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parser_stream.sv
module tb_parser_stream;

  typedef logic [29:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst, flush, iv, fmt, ordy;
  logic [29:0] instr;
  logic        ir, ov, fo, br;
  logic [6:0]  op;
  logic [4:0]  pr;
  logic [15:0] sec;
  logic [15:0] cnt;
  logic [29:0] obs;

  logic        s_iv, s_ir, s_ov;
  logic [29:0] s_instr;
  logic [3:0]  s_cnt;
  logic        unused_sat_fo, unused_sat_br;
  logic [6:0]  unused_sat_op;
  logic [4:0]  unused_sat_pr;
  logic [15:0] unused_sat_sec;

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO of decoded records the DUT should hold, plus NOP count.
  logic [29:0] mq[$];
  int unsigned mcnt = 0;

  always #5 clk = ~clk;

  parser_stream dut (
    .clock_i(clk), .reset_i(rst), .flush_i(flush),
    .in_valid_i(iv), .in_ready_o(ir), .instruction_i(instr), .format_i(fmt),
    .out_valid_o(ov), .out_ready_i(ordy),
    .format_o(fo), .is_branch_o(br), .opcode_o(op),
    .prim_operand_o(pr), .sec_operand_o(sec), .nop_count_o(cnt)
  );

  parser_stream #(.CNT_W(4)) dut_sat (
    .clock_i(clk), .reset_i(rst), .flush_i(1'b0),
    .in_valid_i(s_iv), .in_ready_o(s_ir), .instruction_i(s_instr), .format_i(1'b0),
    .out_valid_o(s_ov), .out_ready_i(1'b1),
    .format_o(unused_sat_fo), .is_branch_o(unused_sat_br), .opcode_o(unused_sat_op),
    .prim_operand_o(unused_sat_pr), .sec_operand_o(unused_sat_sec), .nop_count_o(s_cnt)
  );

  assign obs = {fo, br, op, pr, sec};

  function automatic logic [29:0] exp_rec(input logic [29:0] w, input logic f);
    int unsigned v, b, o, p, s;
    v = 32'(w);
    b = (v >> 28) & 32'h1;
    o = (v >> 21) & 32'h7F;
    p = (v >> 16) & 32'h1F;
    s = f ? (v & 32'hFFFF) : ((v >> 11) & 32'h1F);
    return {f, b[0], o[6:0], p[4:0], s[15:0]};
  endfunction

  function automatic bit is_nop_word(input logic [29:0] w);
    return ((32'(w) >> 21) & 32'h7F) == 0;
  endfunction

  task automatic tick();
    bit m_ready, m_ovalid;
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      m_ready  = mq.size() < 2;
      m_ovalid = mq.size() > 0;
      if (flush) mq.delete();
      else begin
        if (m_ovalid && ordy) void'(mq.pop_front());
        if (iv && m_ready) begin
          if (is_nop_word(instr)) begin
            if (mcnt < 65535) mcnt++;
          end else mq.push_back(exp_rec(instr, fmt));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_words(input word_q_t w, input logic f, input int max_cycles,
                             output word_q_t got);
    int idx = 0;
    bit acc;
    got = {};
    fmt = f;
    for (int c = 0; c < max_cycles; c++) begin
      if (idx < w.size()) begin iv = 1'b1; instr = w[idx]; end
      else iv = 1'b0;
      if (ov && ordy) got.push_back(obs);
      acc = iv && (mq.size() < 2) && !flush && !rst;
      tick();
      if (acc) idx++;
      if (idx >= w.size() && mq.size() == 0) break;
    end
    iv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; iv = 1; instr = 30'h10A3BEEF; fmt = 1; ordy = 1;
    s_iv = 0; s_instr = '0;
    tick(); tick();
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ov); end
    checks++; if (obs !== 30'h0) begin failures++; $display("FAIL reset_fields got=%h exp=0", obs); end
    checks++; if (cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ir); end
    rst = 0; iv = 0;
    tick();
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_ignored_hs got=%b exp=0", ov); end
  endtask

  task automatic test_long_decode();
    fmt = 1; instr = 30'h10A3BEEF; iv = 1; ordy = 1;
    tick();
    iv = 0;
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL long_valid got=%b exp=1", ov); end
    checks++; if ({fo, br, op, pr, sec} !== {1'b1, 1'b1, 7'h05, 5'd3, 16'hBEEF})
      begin failures++; $display("FAIL long_fields got=%h exp=%h", obs, {1'b1, 1'b1, 7'h05, 5'd3, 16'hBEEF}); end
    tick();
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL long_drain got=%b exp=0", ov); end
  endtask

  task automatic test_short_decode();
    fmt = 0; instr = 30'h02474FFF; iv = 1; ordy = 1;
    tick();
    iv = 0;
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL short_valid got=%b exp=1", ov); end
    checks++; if ({fo, br, op, pr, sec} !== {1'b0, 1'b0, 7'h12, 5'd7, 16'h0009})
      begin failures++; $display("FAIL short_fields got=%h exp=%h", obs, {1'b0, 1'b0, 7'h12, 5'd7, 16'h0009}); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [29:0] a = 30'h00A1_1111, b = 30'h10C2_2222, c = 30'h0143_3333, d = 30'h1FE4_4444;
    word_q_t rest, got;
    fmt = 1; ordy = 0;
    iv = 1; instr = a; tick();
    instr = b; tick();
    checks++; if (ir !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", ir); end
    checks++; if (obs !== exp_rec(a, 1'b1) || ov !== 1'b1)
      begin failures++; $display("FAIL bp_hold_a got=%h exp=%h", obs, exp_rec(a, 1'b1)); end
    instr = c; tick();
    checks++; if (obs !== exp_rec(a, 1'b1) || ir !== 1'b0)
      begin failures++; $display("FAIL bp_stable got=%h exp=%h", obs, exp_rec(a, 1'b1)); end
    ordy = 1;
    rest.push_back(c); rest.push_back(d);
    drive_words(rest, 1'b1, 20, got);
    checks++; if (got.size() !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    else begin
      checks++;
      if (got[0] !== exp_rec(a, 1) || got[1] !== exp_rec(b, 1) || got[2] !== exp_rec(c, 1) || got[3] !== exp_rec(d, 1))
        begin failures++; $display("FAIL bp_order got=%h %h %h %h", got[0], got[1], got[2], got[3]); end
    end
  endtask

  task automatic test_nop_filter();
    word_q_t w, got;
    int unsigned base = mcnt;
    ordy = 1;
    w.push_back(30'h0061_2345); w.push_back(30'h0000_0000);
    w.push_back(30'h1000_FFFF); w.push_back(30'h1082_6789);
    drive_words(w, 1'b0, 20, got);
    checks++; if (got.size() !== 2) begin failures++; $display("FAIL nop_count_out got=%0d exp=2", got.size()); end
    else begin
      checks++;
      if (got[0] !== exp_rec(w[0], 0) || got[1] !== exp_rec(w[3], 0))
        begin failures++; $display("FAIL nop_order got=%h %h", got[0], got[1]); end
    end
    checks++; if (cnt !== 16'(base + 2)) begin failures++; $display("FAIL nop_cnt got=%0d exp=%0d", cnt, base + 2); end
  endtask

  task automatic test_saturation();
    s_instr = 30'h0000_0000; s_iv = 1;
    repeat (14) tick();
    s_iv = 0;
    checks++; if (s_cnt !== 4'd14) begin failures++; $display("FAIL sat_mid got=%0d exp=14", s_cnt); end
    s_iv = 1;
    repeat (3) tick();
    s_iv = 0;
    checks++; if (s_cnt !== 4'hF) begin failures++; $display("FAIL sat_hold got=%0d exp=15", s_cnt); end
    checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL sat_no_out got=%b exp=0", s_ov); end
  endtask

  task automatic test_flush();
    word_q_t w, got;
    int unsigned base = mcnt;
    fmt = 1; ordy = 0;
    iv = 1; instr = 30'h00A0_0001; tick();
    instr = 30'h00A0_0002; tick();
    checks++; if (ir !== 1'b0) begin failures++; $display("FAIL flush_setup got=%b exp=0", ir); end
    flush = 1; instr = 30'h00A0_0003; tick();
    flush = 0; iv = 0;
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", ov); end
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", ir); end
    iv = 1; instr = 30'h00A0_0004; tick();
    flush = 1; instr = 30'h1000_1234; tick();
    checks++; if (cnt !== 16'(base)) begin failures++; $display("FAIL flush_nop_cnt got=%0d exp=%0d", cnt, base); end
    instr = 30'h00A0_0005; tick();
    flush = 0; iv = 0;
    ordy = 1;
    w.push_back(30'h00A0_0006);
    drive_words(w, 1'b1, 10, got);
    checks++; if (got.size() !== 1 || got[0] !== exp_rec(w[0], 1))
      begin failures++; $display("FAIL flush_after got_n=%0d first=%h exp=%h", got.size(), (got.size() > 0) ? got[0] : 30'h0, exp_rec(w[0], 1)); end
  endtask

  task automatic test_reset_mid();
    fmt = 1; ordy = 0;
    iv = 1; instr = 30'h0123_4567; tick();
    instr = 30'h0765_4321; tick();
    checks++; if (ir !== 1'b0) begin failures++; $display("FAIL rmid_setup got=%b exp=0", ir); end
    iv = 0; rst = 1; tick();
    rst = 0;
    checks++; if (ov !== 1'b0 || obs !== 30'h0) begin failures++; $display("FAIL rmid_out got=%b/%h exp=0/0", ov, obs); end
    checks++; if (cnt !== 16'h0) begin failures++; $display("FAIL rmid_cnt got=%0d exp=0", cnt); end
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", ir); end
    fmt = 0; ordy = 1; iv = 1; instr = 30'h02474FFF; tick();
    iv = 0;
    checks++; if (ov !== 1'b1 || obs !== exp_rec(30'h02474FFF, 0))
      begin failures++; $display("FAIL rmid_next got=%h exp=%h", obs, exp_rec(30'h02474FFF, 0)); end
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      iv    = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 24) == 0);
      fmt   = $urandom_range(0, 1);
      instr = 30'($urandom);
      if ($urandom_range(0, 3) == 0) instr[27:21] = 7'h0;
      checks++; if (ir !== (mq.size() < 2)) begin failures++; errs++;
        if (errs < 10) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, ir, mq.size() < 2); end
      checks++; if (ov !== (mq.size() > 0)) begin failures++; errs++;
        if (errs < 10) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, ov, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if (obs !== mq[0]) begin failures++; errs++;
          if (errs < 10) $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, obs, mq[0]); end
      end
      checks++; if (cnt !== 16'(mcnt)) begin failures++; errs++;
        if (errs < 10) $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, cnt, mcnt); end
      tick();
    end
    iv = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_long_decode();
    test_short_decode();
    test_backpressure();
    test_nop_filter();
    test_saturation();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parser_stream.md
Name: parser_stream

Overview:
- Parametrised successor to the decode-front parser stage. Splits each fetched instruction word into format, branch flag, opcode, primary register and secondary operand (immediate or register).
- Replaces the single stall input with a valid/ready handshake on both sides and adds a 2-entry skid buffer, flush, and NOP filtering with a statistics counter.
- Sits between the instruction fetch/align stage and the register-read/dispatch stage.

Parameters:
- OP_W, 7, opcode field width; opcode value 0 is NOP.
- REG_W, 5, register-specifier width.
- IMM_W, 16, immediate field width; also the width of the secondary operand output.
- CNT_W, 16, width of the NOP statistics counter.
- Derived (localparam), INSTR_W = IMM_W+REG_W+OP_W+2 (30 at defaults). Field layout:
  - bit INSTR_W-1: reserved, ignored.
  - bit INSTR_W-2: branch.
  - next OP_W bits: opcode.
  - next REG_W bits: primary register.
  - bits [IMM_W-1:0]: immediate; short format uses the register in [IMM_W-1 -: REG_W].

Ports:
- clock_i  in  1  clock; all logic is on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all buffered instructions.
- in_valid_i  in  1  upstream word valid.
- in_ready_o  out  1  parser can accept (registered).
- instruction_i  in  INSTR_W  instruction word.
- format_i  in  1  0 = short (register-register), 1 = long (immediate).
- out_valid_o  out  1  decoded fields valid.
- out_ready_i  in  1  downstream accepts.
- format_o  out  1  format of the presented instruction.
- is_branch_o  out  1  branch bit.
- opcode_o  out  OP_W  opcode.
- prim_operand_o  out  REG_W  primary register.
- sec_operand_o  out  IMM_W  immediate, or zero-extended secondary register.
- nop_count_o  out  CNT_W  NOPs dropped since reset, saturating.

Behaviour:
- Reset (synchronous, reset_i high at the edge):
  - out_valid_o=0, all field outputs 0, nop_count_o=0.
  - Skid buffer emptied; in_ready_o=1 on the first edge after reset.
  - Handshakes presented while reset_i is high are ignored.
- Transfer rules:
  - Input transfer occurs on in_valid_i & in_ready_o.
  - Output transfer occurs on out_valid_o & out_ready_i.
  - Once out_valid_o is asserted, all outputs stay stable until the output transfer.
- Decode:
  - Long format: sec_operand_o = instruction_i[IMM_W-1:0].
  - Short format: sec_operand_o = {zeros, instruction_i[IMM_W-1 -: REG_W]}; the low bits below that field are ignored.
- NOP filtering:
  - An accepted word with opcode 0 is consumed and never presented downstream.
  - nop_count_o increments by 1 and holds at all-ones.
- Latency:
  - An accepted non-NOP word is presented on the output registers at the next edge, provided the output stage is empty or is transferring in the same cycle. Otherwise it goes into the skid register.
  - Order is strictly preserved.
- Skid and backpressure:
  - in_ready_o = !skid_valid, registered.
  - With the output stage held and the skid register full, in_ready_o=0 from the next cycle.
  - When the output transfers, skid contents move to the output stage at the same edge, and in_ready_o returns to 1 on the following cycle.
  - No input word is ever lost or duplicated.
- Simultaneous events:
  - Output transfer plus input accept with the skid empty: the new word replaces the output stage directly.
  - Input NOP plus output transfer: the output drains and the counter increments, both in the same cycle.
- Flush:
  - At the next edge, out_valid_o=0 and the skid buffer is emptied.
  - Any input accepted in the flush cycle is discarded and is not counted as a NOP.
  - nop_count_o is not cleared.
  - Reset has priority over flush.
- Reset mid-operation: buffered instructions are discarded, same as a flush plus counter clear.

Decomposition:
- Shared package pa_isa_pkg holds:
  - Default widths OP_W, REG_W, IMM_W.
  - Constants FMT_SHORT=1'b0, FMT_LONG=1'b1, OPCODE_NOP=0.
  - A packed struct for the decoded instruction: format, branch, opcode, prim, sec.
- One sub-module, parser_skid_buffer:
  - Generic 2-entry valid/ready register slice over the decoded-struct width.
  - Has flush; instantiated after the combinational field split and NOP filter.

Test Plan:
- Long decode: format_i=1, instruction_i=30'h10A3BEEF, out_ready_i=1 → one cycle later out_valid_o=1, is_branch_o=1, opcode_o=7'h05, prim_operand_o=5'd3, sec_operand_o=16'hBEEF.
- Short decode: format_i=0, instruction_i=30'h02474FFF → is_branch_o=0, opcode_o=7'h12, prim_operand_o=5'd7, sec_operand_o=16'h0009 (low 11 bits ignored).
- Backpressure: stream 4 words A,B,C,D with out_ready_i=0 → A held on the output, B in skid, in_ready_o=0, C not accepted. Then out_ready_i=1 → output sequence A,B,C,D, no loss or duplication.
- NOP filtering: send A, 0x00000000, 0x1000FFFF (opcode 0), B → output only A then B; nop_count_o=2. Preload the counter to 16'hFFFF and send another NOP → stays 16'hFFFF.
- Flush: output and skid full; assert flush_i together with in_valid_i → next cycle out_valid_o=0, in_ready_o=1, nothing from the flush cycle ever appears, nop_count_o unchanged.
- Reset mid-stream: reset_i high for 1 cycle with both stages full → all outputs 0, nop_count_o=0, in_ready_o=1 afterwards. A subsequent word decodes with 1-cycle latency.
